// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Brief    : Instruction fetch stage. Keeps the PC, issues one-cycle-latency
//            reads to program memory, buffers returned words in a small FIFO
//            and hands {instr, pc} to decode over valid/ready. A redirect
//            flushes the FIFO and discards any in-flight response.
//            Optional feature macro: FETCH_HALT_EN (stop fetching on
//            HALT_OPCODE and raise halted once decode consumes it).
// Revision : 1.0  initial release
// ============================================================================
module instr_fetch #(
  parameter int unsigned       ADDR_W      = 8,
  parameter int unsigned       DATA_W      = 16,
  parameter int unsigned       DEPTH       = 2,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter logic [DATA_W-1:0] HALT_OPCODE = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              halted
);

`ifdef FETCH_HALT_EN
  localparam bit c_halt_en = 1'b1;
`else
  localparam bit c_halt_en = 1'b0;
`endif
  localparam int unsigned c_ptr_w = $clog2(DEPTH);
  localparam int unsigned c_cnt_w = $clog2(DEPTH + 1);
  localparam int unsigned c_occ_w = c_cnt_w + 1;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  // Issue / return pipeline
  logic [ADDR_W-1:0] r_pc;
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_addr;
  logic              r_ret_valid;  // response on mem_rdata this cycle belongs to the live stream
  logic [ADDR_W-1:0] r_ret_pc;

  // Fetch FIFO
  logic [DATA_W-1:0] r_fifo_instr [DEPTH];
  logic [ADDR_W-1:0] r_fifo_pc    [DEPTH];
  logic [c_ptr_w-1:0] r_wptr;
  logic [c_ptr_w-1:0] r_rptr;
  logic [c_cnt_w-1:0] r_count;

  state_t r_state;

  logic               w_pop;
  logic               w_push;
  logic               w_halt_seen;
  logic               w_halt_pop;
  logic [c_cnt_w-1:0] w_count_next;
  logic               w_inflight_next;
  logic               w_run_next;
  logic [c_occ_w-1:0] w_occ_next;
  logic               w_issue;
  logic [ADDR_W-1:0]  w_issue_pc;

  assign instr_valid = (r_count != '0);
  assign instr       = r_fifo_instr[r_rptr];
  assign instr_pc    = r_fifo_pc[r_rptr];
  assign mem_rd_en   = r_rd_en;
  assign mem_addr    = r_addr;
  assign halted      = c_halt_en & (r_state == S_HALT);

  // A redirect kills the returning word, so it never lands in the FIFO.
  assign w_pop  = instr_valid & instr_ready;
  assign w_push = r_ret_valid & ~redirect_valid;

  // Halt word entering the FIFO; only the first one matters since fetch stops.
  assign w_halt_seen = c_halt_en & w_push & (r_state == S_RUN) & (mem_rdata == HALT_OPCODE);
  // No pushes follow the halt word, so it is the last entry left in DRAIN.
  assign w_halt_pop  = (r_state == S_DRAIN) & w_pop & (r_count == c_cnt_w'(1));

  assign w_count_next    = redirect_valid ? '0
                         : r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
  // The read presented this cycle returns next cycle unless it is now stale.
  assign w_inflight_next = r_rd_en & ~redirect_valid & ~w_halt_seen;
  assign w_run_next      = redirect_valid | ((r_state == S_RUN) & ~w_halt_seen);

  // Every word already promised a FIFO slot is counted, so a new read can
  // never find the FIFO full when its data comes back.
  assign w_occ_next = {1'b0, w_count_next} + c_occ_w'(w_inflight_next);
  assign w_issue    = w_run_next & (w_occ_next < c_occ_w'(DEPTH));
  assign w_issue_pc = redirect_valid ? redirect_pc : r_pc;

  // PC, registered read strobe/address, and tagging of the returning word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc        <= RESET_PC;
      r_rd_en     <= 1'b0;
      r_addr      <= '0;
      r_ret_valid <= 1'b0;
      r_ret_pc    <= '0;
    end else begin
      r_rd_en <= w_issue;
      if (w_issue) begin
        r_addr <= w_issue_pc;
        r_pc   <= w_issue_pc + 1'b1;
      end
      r_ret_valid <= w_inflight_next;
      r_ret_pc    <= r_addr;
    end
  end

  // Fetch FIFO: push returned words, pop on handshake, flush on redirect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_fifo_instr[i] <= '0;
        r_fifo_pc[i]    <= '0;
      end
    end else begin
      r_count <= w_count_next;
      if (redirect_valid) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push) begin
          r_fifo_instr[r_wptr] <= mem_rdata;
          r_fifo_pc[r_wptr]    <= r_ret_pc;
          r_wptr               <= r_wptr + 1'b1;
        end
        if (w_pop) begin
          r_rptr <= r_rptr + 1'b1;
        end
      end
    end
  end

  // Run / drain / halt sequencing; redirect always resumes fetching
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RUN;
    end else if (redirect_valid) begin
      r_state <= S_RUN;
    end else begin
      case (r_state)
        S_RUN:   if (w_halt_seen) r_state <= S_DRAIN;
        S_DRAIN: if (w_halt_pop)  r_state <= S_HALT;
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_RUN;
      endcase
    end
  end

endmodule
`default_nettype wire
